// File: rtl/servo_pwm.sv
// servo_pwm: hobby-servo pulse generator with a one-shot OPEN hold.
// A free-running frame counter produces a fixed-period PWM frame. The pulse
// width of each frame is latched at the frame start from the registered
// CLOSED/OPEN state, so a frame never changes width once it has begun.
// An enable sample moves the servo to OPEN for HOLD_FRAMES frames, after
// which it falls back to CLOSED on its own.
//
// Handshake: enable is a level-sampled trigger with no ready. Every rising
// edge at which enable is high (and rst is low) counts as one trigger. There
// is no backpressure and no acknowledge.
module servo_pwm #(
  parameter int unsigned PERIOD_CYCLES = 1_000_000,
  parameter int unsigned PULSE_CLOSED  = 50_000,
  parameter int unsigned PULSE_OPEN    = 100_000,
  parameter int unsigned HOLD_FRAMES   = 150
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic servo,
  output logic dbg_state_o
);

  // Both pulse widths are below PERIOD_CYCLES, so they fit in the counter width.
  localparam int unsigned CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST     = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] WIDTH_OPEN   = CW'(PULSE_OPEN);
  localparam logic [CW-1:0] WIDTH_CLOSED = CW'(PULSE_CLOSED);
  localparam logic [HW-1:0] HOLD_LOAD    = HW'(HOLD_FRAMES);
  localparam logic [HW-1:0] HOLD_ONE     = HW'(1);

  typedef enum logic [0:0] {
    ST_CLOSED = 1'b0,
    ST_OPEN   = 1'b1
  } state_e;

  state_e          state_q;
  logic [HW-1:0]   hold_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   width_q;
  logic [CW-1:0]   width_d;
  logic            servo_q;
  logic            servo_d;
  logic            frame_start;

  assign frame_start = (cnt_q == '0);

  // Next frame position, per-frame width selection and next output level.
  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    width_d = width_q;
    if (frame_start) begin
      width_d = (state_q == ST_OPEN) ? WIDTH_OPEN : WIDTH_CLOSED;
    end
    servo_d = (cnt_q < width_d);
  end

  // Frame counter, latched width and registered PWM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      width_q <= WIDTH_CLOSED;
      servo_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      width_q <= width_d;
      servo_q <= servo_d;
    end
  end

  // CLOSED/OPEN state with the remaining-frames hold counter; a trigger
  // always reloads the hold and wins over the frame-start decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLOSED;
      hold_q  <= '0;
    end else begin
      case (state_q)
        ST_CLOSED: begin
          if (enable) begin
            state_q <= ST_OPEN;
            hold_q  <= HOLD_LOAD;
          end
        end
        ST_OPEN: begin
          if (enable) begin
            hold_q <= HOLD_LOAD;
          end else if (frame_start) begin
            if (hold_q <= HOLD_ONE) begin
              state_q <= ST_CLOSED;
              hold_q  <= '0;
            end else begin
              hold_q <= hold_q - HOLD_ONE;
            end
          end
        end
        default: begin
          state_q <= ST_CLOSED;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign servo       = servo_q;
  assign dbg_state_o = (state_q == ST_OPEN);

endmodule

// File: tb/tb_servo_pwm.sv
// Bench for servo_pwm with a small frame and short hold.
// The reference model works in whole frames: a frame is OPEN when it is one
// of the first HOLD frame starts strictly after the latest trigger edge.
module tb_servo_pwm;

  localparam int P = 20;
  localparam int C = 2;
  localparam int O = 5;
  localparam int H = 3;

  logic clk;
  logic rst;
  logic enable;
  logic servo;
  logic dbg_state;

  int checks;
  int failures;

  // Expected {state_open, servo} after each edge.
  logic [1:0] exp_q[$];

  // Model bookkeeping.
  int cyc;
  int r0;
  bit in_reset;
  int last_trig;
  bit frame_open;
  int phase;

  servo_pwm #(
    .PERIOD_CYCLES(P),
    .PULSE_CLOSED (C),
    .PULSE_OPEN   (O),
    .HOLD_FRAMES  (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .servo      (servo),
    .dbg_state_o(dbg_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: evaluates each edge from absolute edge times.
  always @(posedge clk) begin : model
    int pos;
    int k;
    int c;
    int trig_frame;
    logic e_servo;
    logic e_open;
    if (rst) begin
      in_reset  = 1'b1;
      last_trig = -1;
      e_servo   = 1'b0;
      e_open    = 1'b0;
      phase     = -1;
    end else begin
      if (in_reset) begin
        r0       = cyc;
        in_reset = 1'b0;
      end
      pos = cyc - r0;
      k   = pos / P;
      c   = pos % P;
      if (c == 0) begin
        if (last_trig >= 0) begin
          trig_frame = (last_trig - r0) / P;
          frame_open = ((k - trig_frame) <= H);
        end else begin
          frame_open = 1'b0;
        end
      end
      e_servo = (c < (frame_open ? O : C));
      if (enable) last_trig = cyc;
      if (last_trig >= 0) begin
        trig_frame = (last_trig - r0) / P;
        e_open = ((k - trig_frame) < H);
      end else begin
        e_open = 1'b0;
      end
      phase = c;
    end
    exp_q.push_back({e_open, e_servo});
    cyc = cyc + 1;
  end

  // Monitor: pops one expectation per cycle, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (servo !== e[0]) begin
        failures = failures + 1;
        $display("FAIL servo cyc=%0d got=%0b exp=%0b", cyc - 1, servo, e[0]);
      end
      checks = checks + 1;
      if (dbg_state !== e[1]) begin
        failures = failures + 1;
        $display("FAIL state cyc=%0d got=%0b exp=%0b", cyc - 1, dbg_state, e[1]);
      end
    end
  end

  function automatic int next_phase();
    if (phase < 0) return 0;
    return (phase + 1) % P;
  endfunction

  // Driver tasks: all inputs change just after a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int target);
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (next_phase() == target) return;
      guard = guard + 1;
      if (guard > 3 * P) begin
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL wait_phase timeout got_phase=%0d exp_phase=%0d", phase, target);
        return;
      end
    end
  endtask

  task automatic trigger_at(input int target);
    wait_phase(target);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic reset_for(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    r0         = 0;
    in_reset   = 1'b1;
    last_trig  = -1;
    frame_open = 1'b0;
    phase      = -1;
    rst        = 1'b1;
    enable     = 1'b0;

    // Reset, then idle CLOSED frames.
    idle(5);
    rst = 1'b0;
    idle(100);

    // Single trigger mid-frame.
    trigger_at(7);
    idle(5 * P);

    // Trigger exactly on a frame-start edge while CLOSED.
    trigger_at(0);
    idle(5 * P);

    // Re-trigger during the second OPEN frame.
    trigger_at(5);
    idle(P);
    idle(P);
    trigger_at(10);
    idle(6 * P);

    // Enable held high for 100 clocks.
    enable = 1'b1;
    idle(100);
    enable = 1'b0;
    idle(6 * P);

    // Reset at cnt=3 of an OPEN frame; the trigger must be forgotten.
    trigger_at(0);
    idle(5);
    wait_phase(3);
    reset_for(2);
    idle(3 * P);

    // Sub-cycle glitch on enable between edges.
    wait_phase(4);
    #1 enable = 1'b1;
    #2 enable = 1'b0;
    idle(2 * P);

    // Randomized triggers with occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 29) == 0);
      rst    = ($urandom_range(0, 249) == 0);
    end
    enable = 1'b0;
    rst    = 1'b0;
    idle(5 * P);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
